uart_rx_front: RTL and testbench
================================

UART_RX_FRONT -- requirements
Module: uart_rx_front

Interface
- REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of RX synchronizer flops; legal values 2..4.
- REQ-002 Port clk, input, 1, SHALL be the single system clock for all logic.
- REQ-003 Port reset, input, 1, SHALL be a synchronous, active-high reset.
- REQ-004 Port rx, input, 1, SHALL be the serial line from the pad-buffer stage; it is asynchronous and idles high.
- REQ-005 Port k, input, 19, SHALL be the clock cycles per bit; legal range 4..2^19-1.
- REQ-006 Port eight, input, 1, SHALL select 8 data bits when 1 and 7 data bits when 0.
- REQ-007 Port pen, input, 1, SHALL add one parity bit when 1.
- REQ-008 Port ohel, input, 1, SHALL select odd parity when 1 and even parity when 0.
- REQ-009 Port clear, input, 1, SHALL be the one-cycle read strobe from core that clears rxrdy and all flags.
- REQ-010 Port data, output, 8, SHALL carry the received character, LSB first on the wire; in 7-bit mode data[7]=0.
- REQ-011 Port rxrdy, output, 1, SHALL mean a character is held in data.
- REQ-012 Ports perr, ferr, ovf, output, 1 each, SHALL flag parity error, framing error and overrun respectively.

Function
- REQ-013 rx SHALL pass through SYNC_STAGES flops before any use; the result is rx_s.
- REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
- REQ-015 IDLE: rx_s=0 SHALL cause a transition to START and load the bit counter with k>>1.
- REQ-016 START: at count expiry, rx_s=1 SHALL return to IDLE as a false start with no flags set; rx_s=0 SHALL go to DATA with the counter reloaded to k.
- REQ-017 DATA: each counter expiry SHALL sample one bit (mid-bit) and shift it in. The DATA state SHALL take N = 7 + eight + pen samples, then go to STOP.
- REQ-018 STOP: at counter expiry the FSM SHALL sample the stop bit, complete the frame and return to IDLE in the same cycle.
- REQ-019 rxrdy SHALL assert in the cycle after the stop-bit sample.
- REQ-020 At frame completion, data, perr and ferr SHALL update together.
- REQ-021 perr SHALL be 1 when pen=1 and the XOR of the data bits and the parity bit does not equal ohel; perr SHALL be 0 when pen=0.
- REQ-022 ferr SHALL be 1 when the stop sample equals 0; the character SHALL still be delivered and rxrdy still asserted.
- REQ-023 Overrun: if a frame completes while rxrdy=1 and clear=0, ovf SHALL be set, and data, perr and ferr SHALL be overwritten with the new frame.
- REQ-024 If clear and frame completion occur in the same cycle, completion SHALL win: rxrdy=1, flags SHALL come from the new frame, and ovf SHALL be 0.
- REQ-025 clear alone SHALL drive rxrdy, perr, ferr and ovf to 0 on the next edge; data SHALL hold its value.
- REQ-026 The counter SHALL count down to 1. Expiry is the cycle where count=1, and the counter SHALL reload in that same cycle.
- REQ-027 Changes to k, eight, pen or ohel while not in IDLE are unsupported; the frame SHALL complete with no hang, but its result is undefined.

Reset
- REQ-028 Reset SHALL put the FSM in IDLE and clear the counter and shift register to 0.
- REQ-029 Reset SHALL drive data=0x00 and rxrdy=perr=ferr=ovf=0.
- REQ-030 Reset SHALL preset all synchronizer flops to 1.
- REQ-031 Reset asserted mid-frame SHALL abort the frame, with no flag or rxrdy produced.

Configuration
- REQ-032 Macro UART_RX_MAJORITY_EN, when defined, SHALL insert a 3-tap majority filter after the synchronizer; the FSM SHALL then use the filtered value, adding 1 cycle of latency to REQ-019 relative to rx.
- REQ-033 With UART_RX_MAJORITY_EN defined, single-cycle glitches on rx SHALL be rejected.
- REQ-034 Without UART_RX_MAJORITY_EN, rx_s SHALL feed the FSM directly.

Verification
- REQ-035 Stimulus: k=10, eight=1, pen=0; send 0xA5 with a good stop bit. Required: data=0xA5 and rxrdy=1 at frame end, with perr=ferr=ovf=0.
- REQ-036 Stimulus: k=10, eight=1, pen=1, ohel=0; send 0x03 with parity bit 1. Required: perr=1, data=0x03.
- REQ-037 Stimulus: k=10, eight=0, pen=0; send 0x41 with stop bit 0. Required: data=0x41, ferr=1, rxrdy=1.
- REQ-038 Stimulus: k=10; a 3-cycle low pulse on rx. Required: FSM returns to IDLE and rxrdy stays 0.
- REQ-039 Stimulus: k=10; send 0x11 then 0x22 with no clear. Required: data=0x22, ovf=1. Repeat with clear coincident with the second completion. Required: ovf=0.
- REQ-040 Stimulus: assert reset mid-DATA, then send 0x5A. Required: no output from the aborted frame; data=0x5A delivered cleanly.

Source files
------------

// File: rtl/uart_rx_front.sv
// UART receive front end: synchronizes rx, frames start/data/parity/stop bits and flags errors.
// Define UART_RX_MAJORITY_EN to insert a 3-tap majority glitch filter after the synchronizer.
module uart_rx_front #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic [18:0] k,
   input  logic        eight,
   input  logic        pen,
   input  logic        ohel,
   input  logic        clear,
   output logic [7:0]  data,
   output logic        rxrdy,
   output logic        perr,
   output logic        ferr,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   rx_f;

   // Synchronizer presets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign rx_f = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign rx_f = rx_s;
`endif

   state_t      state;
   logic [18:0] cnt;
   logic [8:0]  shift_q;
   logic [3:0]  bit_idx;
   logic [3:0]  n_bits;
   logic        expire;
   logic [8:0]  frame;
   logic [7:0]  rx_data;
   logic        par_bit;
   logic        par_err;

   // Samples enter at the top of shift_q, so the frame is right-aligned by shifting out unused slots.
   always_comb begin
      n_bits  = 4'd7 + {3'b000, eight} + {3'b000, pen};
      expire  = (cnt <= 19'd1);
      frame   = shift_q >> (4'd9 - n_bits);
      rx_data = eight ? frame[7:0] : {1'b0, frame[6:0]};
      par_bit = pen & frame[4'd7 + {3'b000, eight}];
      par_err = pen & ((^rx_data ^ par_bit) != ohel);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         shift_q <= '0;
         bit_idx <= '0;
         data    <= '0;
         rxrdy   <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (clear) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!rx_f) begin
                  state <= START;
                  cnt   <= k >> 1;
               end
            end
            START: begin
               if (expire) begin
                  cnt     <= k;
                  bit_idx <= '0;
                  state   <= rx_f ? IDLE : DATA;
               end else begin
                  cnt <= cnt - 19'd1;
               end
            end
            DATA: begin
               if (expire) begin
                  cnt     <= k;
                  shift_q <= {rx_f, shift_q[8:1]};
                  bit_idx <= bit_idx + 4'd1;
                  if (bit_idx >= n_bits - 4'd1) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt - 19'd1;
               end
            end
            STOP: begin
               // Completion overrides a coincident clear: new frame wins and no overrun is flagged.
               if (expire) begin
                  cnt   <= k;
                  state <= IDLE;
                  data  <= rx_data;
                  perr  <= par_err;
                  ferr  <= ~rx_f;
                  rxrdy <= 1'b1;
                  ovf   <= (ovf | rxrdy) & ~clear;
               end else begin
                  cnt <= cnt - 19'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_front.sv
// Self-checking bench for uart_rx_front: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_front;

   localparam int SYNC = 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [18:0] k;
   logic        eight;
   logic        pen;
   logic        ohel;
   logic        clear;
   logic [7:0]  data;
   logic        rxrdy;
   logic        perr;
   logic        ferr;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_data;
   logic       m_rdy;
   logic       m_perr;
   logic       m_ferr;
   logic       m_ovf;

   uart_rx_front #(.SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .k     (k),
      .eight (eight),
      .pen   (pen),
      .ohel  (ohel),
      .clear (clear),
      .data  (data),
      .rxrdy (rxrdy),
      .perr  (perr),
      .ferr  (ferr),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Edges from the start-bit drive to the stop-bit sample edge.
   function automatic int frame_latency();
      return SYNC + MAJ + int'(k >> 1) + int'(k) * (8 + int'(eight) + int'(pen));
   endfunction

   function automatic logic [7:0] model_data(input logic [7:0] b);
      return eight ? b : {1'b0, b[6:0]};
   endfunction

   task automatic model_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit,
                              input logic coincident_clear);
      logic [7:0] d;
      d      = model_data(b);
      m_ovf  = coincident_clear ? 1'b0 : (m_ovf | m_rdy);
      m_data = d;
      m_perr = pen && ((^d ^ par_bit) != ohel);
      m_ferr = !stop_bit;
      m_rdy  = 1'b1;
   endtask

   task automatic model_reset();
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic par_bit, input logic stop_bit);
      int nd;
      nd = 7 + int'(eight);
      @(negedge clk);
      rx = 1'b0;
      for (int i = 0; i < nd; i++) begin
         repeat (k) @(negedge clk);
         rx = b[i];
      end
      if (pen) begin
         repeat (k) @(negedge clk);
         rx = par_bit;
      end
      repeat (k) @(negedge clk);
      rx = stop_bit;
      repeat (k) @(negedge clk);
      rx = 1'b1;
      repeat (2 * k) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_rdy  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx    = 1'b1;
      clear = 1'b0;
      k     = 19'd10;
      eight = 1'b1;
      pen   = 1'b0;
      ohel  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
      checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rxrdy: got %b expected 0", rxrdy); end
      checks++; if (perr !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", perr); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", ferr); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      k = 19'd10; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
      fork
         applyStimulus(8'hA5, 1'b0, 1'b1);
         begin
            int c;
            c = frame_latency();
            @(negedge clk);
            repeat (c) @(negedge clk);
            checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got rxrdy=%b expected 0", rxrdy); end
            @(negedge clk);
            checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL latency_rdy: got rxrdy=%b expected 1", rxrdy); end
         end
      join
      model_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      checks++; if (data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", data); end
      checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL basic_rxrdy: got %b expected 1", rxrdy); end
      checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("[TB] FAIL basic_flags: got %b expected 000", {perr, ferr, ovf}); end
   endtask

   task automatic test_parity();
      do_clear();
      k = 19'd10; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
      applyStimulus(8'h03, 1'b1, 1'b1);
      model_frame(8'h03, 1'b1, 1'b1, 1'b0);
      checks++; if (perr !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_perr: got %b expected 1", perr); end
      checks++; if (data !== 8'h03) begin errors++; $display("[TB] FAIL parity_bad_data: got %h expected 03", data); end
      do_clear();
      ohel = 1'b1;
      applyStimulus(8'h03, 1'b1, 1'b1);
      model_frame(8'h03, 1'b1, 1'b1, 1'b0);
      checks++; if (perr !== 1'b0) begin errors++; $display("[TB] FAIL parity_odd_perr: got %b expected 0", perr); end
      checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL parity_odd_rxrdy: got %b expected 1", rxrdy); end
   endtask

   task automatic test_framing();
      do_clear();
      k = 19'd10; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
      applyStimulus(8'h41, 1'b0, 1'b0);
      model_frame(8'h41, 1'b0, 1'b0, 1'b0);
      checks++; if (data !== 8'h41) begin errors++; $display("[TB] FAIL framing_data: got %h expected 41", data); end
      checks++; if (ferr !== 1'b1) begin errors++; $display("[TB] FAIL framing_ferr: got %b expected 1", ferr); end
      checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL framing_rxrdy: got %b expected 1", rxrdy); end
   endtask

   task automatic test_clear();
      do_clear();
      checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL clear_rxrdy: got %b expected 0", rxrdy); end
      checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("[TB] FAIL clear_flags: got %b expected 000", {perr, ferr, ovf}); end
      checks++; if (data !== m_data) begin errors++; $display("[TB] FAIL clear_data_hold: got %h expected %h", data, m_data); end
   endtask

   task automatic test_false_start();
      k = 19'd10; eight = 1'b1; pen = 1'b0;
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL false_start_rxrdy: got %b expected 0", rxrdy); end
      checks++; if (data !== m_data) begin errors++; $display("[TB] FAIL false_start_data: got %h expected %h", data, m_data); end
      applyStimulus(8'h3C, 1'b0, 1'b1);
      model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      checks++; if (data !== 8'h3C) begin errors++; $display("[TB] FAIL after_false_data: got %h expected 3c", data); end
   endtask

   task automatic test_back_to_back();
      do_clear();
      k = 19'd10; eight = 1'b1; pen = 1'b0;
      applyStimulus(8'h11, 1'b0, 1'b1);
      model_frame(8'h11, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h22, 1'b0, 1'b1);
      model_frame(8'h22, 1'b0, 1'b1, 1'b0);
      checks++; if (data !== 8'h22) begin errors++; $display("[TB] FAIL overrun_data: got %h expected 22", data); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL overrun_ovf: got %b expected 1", ovf); end
      do_clear();
      applyStimulus(8'h11, 1'b0, 1'b1);
      model_frame(8'h11, 1'b0, 1'b1, 1'b0);
      fork
         applyStimulus(8'h22, 1'b0, 1'b1);
         begin
            int c;
            c = frame_latency();
            @(negedge clk);
            repeat (c) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
         end
      join
      model_frame(8'h22, 1'b0, 1'b1, 1'b1);
      checks++; if (data !== 8'h22) begin errors++; $display("[TB] FAIL coincident_data: got %h expected 22", data); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL coincident_ovf: got %b expected 0", ovf); end
      checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL coincident_rxrdy: got %b expected 1", rxrdy); end
   endtask

   task automatic test_reset_mid_frame();
      k = 19'd10; eight = 1'b1; pen = 1'b0;
      @(negedge clk);
      rx = 1'b0;
      repeat (k) @(negedge clk);
      rx = 1'b1;
      repeat (k) @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (3 * k) @(negedge clk);
      checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL abort_rxrdy: got %b expected 0", rxrdy); end
      checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("[TB] FAIL abort_flags: got %b expected 000", {perr, ferr, ovf}); end
      checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL abort_data: got %h expected 00", data); end
      applyStimulus(8'h5A, 1'b0, 1'b1);
      model_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      checks++; if (data !== 8'h5A) begin errors++; $display("[TB] FAIL after_abort_data: got %h expected 5a", data); end
      checks++; if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin errors++; $display("[TB] FAIL after_abort_status: got %b expected 1000", {rxrdy, perr, ferr, ovf}); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       par_bit;
      logic       stop_bit;
      for (int n = 0; n < 24; n++) begin
         k     = 19'(2 * $urandom_range(2, 8));
         eight = 1'($urandom_range(0, 1));
         pen   = 1'($urandom_range(0, 1));
         ohel  = 1'($urandom_range(0, 1));
         b     = 8'($urandom);
         par_bit  = ohel ^ (^model_data(b)) ^ ($urandom_range(0, 3) == 0);
         stop_bit = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 2) == 0) do_clear();
         applyStimulus(b, par_bit, stop_bit);
         model_frame(b, par_bit, stop_bit, 1'b0);
         checks++; if (data !== m_data) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", n, data, m_data); end
         checks++; if (rxrdy !== m_rdy) begin errors++; $display("[TB] FAIL rand_rxrdy[%0d]: got %b expected %b", n, rxrdy, m_rdy); end
         checks++; if (perr !== m_perr) begin errors++; $display("[TB] FAIL rand_perr[%0d]: got %b expected %b", n, perr, m_perr); end
         checks++; if (ferr !== m_ferr) begin errors++; $display("[TB] FAIL rand_ferr[%0d]: got %b expected %b", n, ferr, m_ferr); end
         checks++; if (ovf !== m_ovf) begin errors++; $display("[TB] FAIL rand_ovf[%0d]: got %b expected %b", n, ovf, m_ovf); end
      end
   endtask

   initial begin
      $display("[TB] starting uart_rx_front bench");
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_clear();
      test_false_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
